// File: rtl/ps2_kbd_event_rx_if.sv
// Key-event pop port of the PS/2 keyboard receiver.
// master: drives the FIFO head (valid/code/ext/break) and samples ready.
// slave : the consumer; samples the head and drives ready.
interface ps2_kbd_event_rx_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;

  modport master (output evt_valid, evt_code, evt_ext, evt_break, input evt_ready);
  modport slave  (input evt_valid, evt_code, evt_ext, evt_break, output evt_ready);
endinterface

// File: rtl/ps2_kbd_event_rx.sv
// PS/2 keyboard receiver: 11-bit frame check, E0/F0 prefix decode, FWFT event FIFO,
// plus make counter / held flag / last make code for display logic.
// Latency: evt_valid rises 3 clk after the stop-bit fall is detected (empty FIFO).
// Backpressure: events wait in the FIFO; when full, new events are dropped and
// o_overflow sticks until reset.
// Ports: i_clk, i_rst (sync, active-high), i_ps2_clk/i_ps2_data (async pins),
//   evt_if (master: evt_valid/evt_ready/evt_code/evt_ext/evt_break), o_fifo_level,
//   o_press_count, o_last_code, o_held, o_frame_err (pulse), o_overflow (sticky).
// Optional feature macro: PS2_TYPEMATIC_FILTER_EN (suppress auto-repeat makes).
module ps2_kbd_event_rx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 10000,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_ps2_clk,
  input  logic                i_ps2_data,
  ps2_kbd_event_rx_if.master  evt_if,
  output logic [LVL_W-1:0]    o_fifo_level,
  output logic [CNT_W-1:0]    o_press_count,
  output logic [7:0]          o_last_code,
  output logic                o_held,
  output logic                o_frame_err,
  output logic                o_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  // ---------------- pin synchronisers ----------------
  logic r_clk_s1, r_clk_s2, r_clk_s3;
  logic r_dat_s1, r_dat_s2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_clk_s1 <= 1'b0;
      r_clk_s2 <= 1'b0;
      r_clk_s3 <= 1'b0;
      r_dat_s1 <= 1'b0;
      r_dat_s2 <= 1'b0;
    end else begin
      r_clk_s1 <= i_ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_s3 <= r_clk_s2;
      r_dat_s1 <= i_ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  logic w_fall;
  assign w_fall = r_clk_s3 & ~r_clk_s2;

  // ---------------- frame receiver ----------------
  logic [3:0]      r_bit_cnt;
  logic [9:0]      r_sh;       // bits 0..9 of the frame, bit 0 ends up at [0]
  logic [TO_W-1:0] r_to_cnt;
  logic            r_byte_vld;
  logic [7:0]      r_byte;
  logic            r_frame_err;

  logic [10:0] w_frame;
  logic        w_frame_ok;
  logic        w_timeout;

  // Current sample completes the frame when the 11th fall (stop bit) arrives.
  assign w_frame    = {r_dat_s2, r_sh};
  assign w_frame_ok = ~w_frame[0] & (^w_frame[9:1]) & w_frame[10];
  assign w_timeout  = (r_bit_cnt != 4'd0) && !w_fall &&
                      (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bit_cnt   <= '0;
      r_sh        <= '0;
      r_to_cnt    <= '0;
      r_byte_vld  <= 1'b0;
      r_byte      <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_byte_vld  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_fall) begin
        r_to_cnt <= '0;
        if (r_bit_cnt == 4'd10) begin
          r_bit_cnt <= '0;
          if (w_frame_ok) begin
            r_byte_vld <= 1'b1;
            r_byte     <= w_frame[8:1];
          end else begin
            r_frame_err <= 1'b1;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
          r_sh      <= {r_dat_s2, r_sh[9:1]};
        end
      end else if (w_timeout) begin
        r_bit_cnt   <= '0;
        r_to_cnt    <= '0;
        r_frame_err <= 1'b1;
      end else if (r_bit_cnt != 4'd0) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
    end
  end

  // ---------------- prefix decoder ----------------
  logic [1:0] r_state;
  logic [1:0] w_nxt;
  logic       w_emit, w_ext, w_brk;

  always_comb begin
    w_nxt  = r_state;
    w_emit = 1'b0;
    w_ext  = 1'b0;
    w_brk  = 1'b0;
    if (r_byte_vld) begin
      case (r_state)
        ST_IDLE: begin
          if (r_byte == 8'hE0)      w_nxt = ST_EXT;
          else if (r_byte == 8'hF0) w_nxt = ST_BRK;
          else                      w_emit = 1'b1;
        end
        ST_EXT: begin
          if (r_byte == 8'hF0)      w_nxt = ST_EXT_BRK;
          else if (r_byte != 8'hE0) begin
            w_emit = 1'b1;
            w_ext  = 1'b1;
            w_nxt  = ST_IDLE;
          end
        end
        ST_BRK: begin
          w_emit = 1'b1;
          w_brk  = 1'b1;
          w_nxt  = ST_IDLE;
        end
        default: begin
          w_emit = 1'b1;
          w_ext  = 1'b1;
          w_brk  = 1'b1;
          w_nxt  = ST_IDLE;
        end
      endcase
    end
  end

  logic             r_last_ext;
  logic [7:0]       r_last_code;
  logic             r_held;
  logic [CNT_W-1:0] r_press;
  logic             r_emit_vld;
  logic [9:0]       r_emit_dat;   // {ext, brk, code}

  logic w_same, w_make_ok, w_brk_ev;
  assign w_same   = (r_last_ext == w_ext) && (r_last_code == r_byte);
  assign w_brk_ev = w_emit & w_brk;
`ifdef PS2_TYPEMATIC_FILTER_EN
  // Auto-repeat of the key already down produces no event at all.
  assign w_make_ok = w_emit & ~w_brk & ~(r_held & w_same);
`else
  assign w_make_ok = w_emit & ~w_brk;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_last_ext  <= 1'b0;
      r_last_code <= '0;
      r_held      <= 1'b0;
      r_press     <= '0;
      r_emit_vld  <= 1'b0;
      r_emit_dat  <= '0;
    end else begin
      r_state    <= w_nxt;
      r_emit_vld <= w_make_ok | w_brk_ev;
      r_emit_dat <= {w_ext, w_brk, r_byte};
      // Make bookkeeping happens here so it counts even if the FIFO drops it.
      if (w_make_ok) begin
        r_press     <= r_press + CNT_W'(1);
        r_last_code <= r_byte;
        r_last_ext  <= w_ext;
        r_held      <= 1'b1;
      end else if (w_brk_ev && w_same) begin
        r_held <= 1'b0;
      end
    end
  end

  // ---------------- FWFT event FIFO ----------------
  logic [9:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr, r_rd;
  logic [LVL_W-1:0] r_level;
  logic             r_ovf;

  logic w_pop, w_full, w_push;
  assign w_pop  = (r_level != '0) & evt_if.evt_ready;
  assign w_full = (r_level == LVL_W'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot the push needs.
  assign w_push = r_emit_vld & (~w_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= r_emit_dat;
        r_wr        <= r_wr + PTR_W'(1);
      end
      if (w_pop) r_rd <= r_rd + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      if (r_emit_vld && !w_push) r_ovf <= 1'b1;
    end
  end

  assign evt_if.evt_valid = (r_level != '0);
  assign evt_if.evt_ext   = r_mem[r_rd][9];
  assign evt_if.evt_break = r_mem[r_rd][8];
  assign evt_if.evt_code  = r_mem[r_rd][7:0];

  assign o_fifo_level  = r_level;
  assign o_press_count = r_press;
  assign o_last_code   = r_last_code;
  assign o_held        = r_held;
  assign o_frame_err   = r_frame_err;
  assign o_overflow    = r_ovf;

endmodule

// File: tb/tb_ps2_kbd_event_rx.sv
module tb_ps2_kbd_event_rx;
  localparam int DEPTH = 8;
  localparam int CNTW  = 8;
  localparam int TOC   = 200;
  localparam int HALF  = 8;
  localparam int LVLW  = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic [LVLW-1:0] fifo_level;
  logic [CNTW-1:0] press_count;
  logic [7:0]      last_code;
  logic            held, frame_err, overflow;

  ps2_kbd_event_rx_if evt_if();

  ps2_kbd_event_rx #(.FIFO_DEPTH(DEPTH), .CNT_W(CNTW), .TIMEOUT_CYC(TOC)) dut (
    .i_clk(clk), .i_rst(rst), .i_ps2_clk(ps2_clk), .i_ps2_data(ps2_data),
    .evt_if(evt_if), .o_fifo_level(fifo_level), .o_press_count(press_count),
    .o_last_code(last_code), .o_held(held), .o_frame_err(frame_err),
    .o_overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard + reference model ----------------
  logic [9:0] sb_q[$];     // {ext, brk, code}
  logic [9:0] sb_exp;
  int         ev_cnt = 0;
  int         fe_cnt = 0;

  logic [1:0] m_state;     // 0 idle, 1 ext, 2 brk, 3 ext_brk
  logic [7:0] m_press;
  logic [7:0] m_last_code;
  logic       m_last_ext;
  logic       m_held;

  task automatic model_reset();
    sb_q.delete();
    m_state = 0; m_press = 0; m_last_code = 0; m_last_ext = 0; m_held = 0;
  endtask

  task automatic model_emit(input logic ext, input logic brk, input logic [7:0] code);
    logic same, keep;
    same = ({m_last_ext, m_last_code} == {ext, code});
    keep = 1'b1;
    if (!brk) begin
`ifdef PS2_TYPEMATIC_FILTER_EN
      if (m_held && same) keep = 1'b0;
`endif
      if (keep) begin
        m_press = m_press + 8'd1;
        m_last_code = code; m_last_ext = ext; m_held = 1'b1;
      end
    end else if (same) begin
      m_held = 1'b0;
    end
    if (keep && sb_q.size() < DEPTH) sb_q.push_back({ext, brk, code});
  endtask

  task automatic model_byte(input logic [7:0] d);
    case (m_state)
      2'd0: if (d == 8'hE0) m_state = 1; else if (d == 8'hF0) m_state = 2;
            else model_emit(1'b0, 1'b0, d);
      2'd1: if (d == 8'hF0) m_state = 3;
            else if (d != 8'hE0) begin model_emit(1'b1, 1'b0, d); m_state = 0; end
      2'd2: begin model_emit(1'b0, 1'b1, d); m_state = 0; end
      default: begin model_emit(1'b1, 1'b1, d); m_state = 0; end
    endcase
  endtask

  always @(negedge clk) begin
    if (!rst && frame_err === 1'b1) fe_cnt++;
    if (!rst && evt_if.evt_valid === 1'b1 && evt_if.evt_ready === 1'b1) begin
      ev_cnt++;
      if (sb_q.size() == 0) chk("sb_underflow", 32'(sb_q.size()), 32'd1);
      else begin
        sb_exp = sb_q.pop_front();
        chk("evt", {22'd0, evt_if.evt_ext, evt_if.evt_break, evt_if.evt_code},
            {22'd0, sb_exp});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int n, input bit chk_lat);
    for (int b = 0; b < n; b++) begin
      ps2_data = f[b];
      repeat (HALF) tick();
      ps2_clk = 1'b0;
      for (int c = 0; c < HALF; c++) begin
        @(negedge clk);
        if (chk_lat && b == n - 1) begin
          if (c == 4) chk("lat_early", 32'(evt_if.evt_valid), 32'd0);
          if (c == 5) chk("lat_exact", 32'(evt_if.evt_valid), 32'd1);
        end
      end
      tick();
      ps2_clk = 1'b1;
    end
    repeat (HALF) tick();
    ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit good);
    return {1'b1, good ? ~^d : ^d, d, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] d, input bit good = 1, input bit chk_lat = 0);
    if (good) model_byte(d);
    send_bits(mk_frame(d, good), 11, chk_lat);
    repeat (8) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (3) tick();
    model_reset();
    rst = 1'b0;
    tick();
  endtask

  int fe0, ev0;
  logic [7:0] p0;

  initial begin
    evt_if.evt_ready = 1'b1;
    do_reset();
    chk("rst_valid", 32'(evt_if.evt_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_press", 32'(press_count), 32'd0);
    chk("rst_last", 32'(last_code), 32'd0);
    chk("rst_held", 32'(held), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);

    // single make, with latency check on the stop bit
    send_byte(8'h1C, 1, 1);
    chk("t1_press", 32'(press_count), 32'd1);
    chk("t1_last", 32'(last_code), 32'h1C);
    chk("t1_held", 32'(held), 32'd1);

    // release
    send_byte(8'hF0); send_byte(8'h1C);
    chk("t2_press", 32'(press_count), 32'd1);
    chk("t2_held", 32'(held), 32'd0);

    // extended make / break
    send_byte(8'hE0); send_byte(8'h75);
    chk("t3_held_mk", 32'(held), 32'd1);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    chk("t3_press", 32'(press_count), 32'd2);
    chk("t3_last", 32'(last_code), 32'h75);
    chk("t3_held", 32'(held), 32'd0);

    // bad parity, then a truncated frame that times out
    fe0 = fe_cnt; p0 = press_count;
    send_byte(8'h1C, 0);
    send_bits(mk_frame(8'h2A, 1), 3, 0);
    repeat (TOC + 20) tick();
    chk("t4_ferr", 32'(fe_cnt - fe0), 32'd2);
    chk("t4_level", 32'(fifo_level), 32'd0);
    chk("t4_press", 32'(press_count), 32'(p0));

    // reset in the middle of a frame; next frame is clean
    send_bits(mk_frame(8'h33, 1), 4, 0);
    do_reset();
    send_byte(8'h34);
    chk("t5_press", 32'(press_count), 32'd1);
    chk("t5_last", 32'(last_code), 32'h34);

    // overflow: DEPTH+1 distinct makes with consumer stalled
    do_reset();
    evt_if.evt_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) send_byte(8'h21 + 8'(i));
    chk("t6_level", 32'(fifo_level), 32'(DEPTH));
    chk("t6_ovf", 32'(overflow), 32'd1);
    chk("t6_press", 32'(press_count), 32'(DEPTH + 1));
    ev0 = ev_cnt;
    evt_if.evt_ready = 1'b1;
    for (int i = 0; i < 100 && fifo_level != 0; i++) tick();
    chk("t6_drain", 32'(fifo_level), 32'd0);
    chk("t6_popped", 32'(ev_cnt - ev0), 32'(DEPTH));
    chk("t6_ovf_sticky", 32'(overflow), 32'd1);

    // auto-repeat of the same make
    p0 = press_count; ev0 = ev_cnt;
    send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
`ifdef PS2_TYPEMATIC_FILTER_EN
    chk("t7_press", 32'(press_count - p0), 32'd1);
    chk("t7_events", 32'(ev_cnt - ev0), 32'd1);
`else
    chk("t7_press", 32'(press_count - p0), 32'd3);
    chk("t7_events", 32'(ev_cnt - ev0), 32'd3);
`endif
    chk("t7_held", 32'(held), 32'd1);

    repeat (10) tick();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
